// File: rtl/prog_fetch8.sv
// Byte-serial instruction fetch unit: assembles INSTR_BYTES little-endian bytes
// from a byte-wide combinational-read memory and holds them until accepted.
module prog_fetch8 #(
    parameter int          INSTR_BYTES = 4,
    parameter logic [7:0]  RESET_PC    = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  mem_addr,
    input  logic [7:0]  mem_data,
    input  logic        halt,
    input  logic        jump_en,
    input  logic [7:0]  jump_addr,
    output logic [31:0] instr,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(INSTR_BYTES - 1);

    state_t      state_q, state_d;
    logic [7:0]  fptr_q, fptr_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            return val;
        end else begin
            return val + 16'd1;
        end
    endfunction

    // Next-state: jump beats halt and capture; an accept in the jump cycle still counts
    always_comb begin
        state_d       = state_q;
        fptr_d        = fptr_q;
        idx_d         = idx_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fetch_count_d = fetch_count_q;

        if (jump_en) begin
            if ((state_q == HOLD) && instr_ready) begin
                fetch_count_d = sat_inc(fetch_count_q);
            end else begin
                fetch_count_d = fetch_count_q;
            end
            fptr_d  = jump_addr;
            idx_d   = 2'd0;
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!halt) begin
                        if (idx_q == 2'd0) begin
                            instr_d    = 32'h0000_0000;
                            instr_pc_d = fptr_q;
                        end else begin
                            instr_pc_d = instr_pc_q;
                        end
                        instr_d[{idx_q, 3'b000} +: 8] = mem_data;
                        fptr_d = fptr_q + 8'd1;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = 2'd0;
                            state_d = HOLD;
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            state_d = FETCH;
                        end
                    end else begin
                        state_d = FETCH;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        fetch_count_d = sat_inc(fetch_count_q);
                        state_d       = FETCH;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = FETCH;
                    idx_d   = 2'd0;
                end
            endcase
        end

        instr_valid_d = (state_d == HOLD);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            fptr_q        <= RESET_PC;
            idx_q         <= 2'd0;
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 8'h00;
            instr_valid_q <= 1'b0;
            fetch_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            fptr_q        <= fptr_d;
            idx_q         <= idx_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign mem_addr    = fptr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_prog_fetch8.sv
// Directed bench for prog_fetch8: a cycle table for the basic fetch stream plus
// hand sequences for stall, jump, wrap, halt and reset corner cases.
module tb_prog_fetch8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        halt;
    logic        jump_en;
    logic [7:0]  jump_addr;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] fetch_count;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

    // Bytes 00..07 are 01..08; elsewhere addr ^ A5 so every byte is distinct
    assign mem_data = mem[mem_addr];

    prog_fetch8 #(.INSTR_BYTES(4), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
        .halt(halt), .jump_en(jump_en), .jump_addr(jump_addr),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        halt;
        logic        jen;
        logic [7:0]  jaddr;
        logic        ready;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [7:0]  e_pc;
        logic [7:0]  e_addr;
        logic [15:0] e_count;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic h, input logic j, input logic [7:0] ja,
                        input logic rdy);
        rst = r; halt = h; jump_en = j; jump_addr = ja; instr_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic v, input logic [31:0] i,
                           input logic [7:0] pc, input logic [7:0] a, input logic [15:0] c);
        chk({name, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
        chk({name, ".instr"}, instr, i);
        chk({name, ".pc"}, {24'd0, instr_pc}, {24'd0, pc});
        chk({name, ".addr"}, {24'd0, mem_addr}, {24'd0, a});
        chk({name, ".count"}, {16'd0, fetch_count}, {16'd0, c});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = (i < 8) ? 8'(i + 1) : (8'(i) ^ 8'hA5);
        end
        rst = 1'b1; halt = 1'b0; jump_en = 1'b0; jump_addr = 8'h00; instr_ready = 1'b0;

        //          rst   halt  jen   jaddr  rdy   valid instr          pc     addr   count
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0000, 8'h00, 8'h00, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0001, 8'h00, 8'h01, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0201, 8'h00, 8'h02, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0003_0201, 8'h00, 8'h03, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0403_0201, 8'h00, 8'h04, 16'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0403_0201, 8'h00, 8'h04, 16'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0005, 8'h04, 8'h05, 16'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000_0605, 8'h04, 8'h06, 16'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0007_0605, 8'h04, 8'h07, 16'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0807_0605, 8'h04, 8'h08, 16'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0807_0605, 8'h04, 8'h08, 16'd2};

        for (int v = 0; v < 11; v++) begin
            step(vecs[v].rst, vecs[v].halt, vecs[v].jen, vecs[v].jaddr, vecs[v].ready);
            chk_all($sformatf("vec%0d", v), vecs[v].e_valid, vecs[v].e_instr,
                    vecs[v].e_pc, vecs[v].e_addr, vecs[v].e_count);
        end

        // Downstream stall: output frozen for 10 cycles, then one accept
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 10; c++) begin
            chk_all($sformatf("stall%0d", c), 1'b1, 32'h0403_0201, 8'h00, 8'h04, 16'd0);
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk_all("stall_accept", 1'b0, 32'h0403_0201, 8'h00, 8'h04, 16'd1);

        // Jump after two bytes, asserted together with halt
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h80, 1'b1);
        chk_all("jump80", 1'b0, 32'h0000_0201, 8'h00, 8'h80, 16'd0);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk({"jump80_early", ".valid"}, {31'd0, instr_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("jump80_instr", 1'b1, 32'h2627_2425, 8'h80, 8'h84, 16'd0);

        // Jump while holding with ready high: counts the accept, then redirects across the wrap
        step(1'b0, 1'b0, 1'b1, 8'hFE, 1'b1);
        chk_all("jump_accept", 1'b0, 32'h2627_2425, 8'h80, 8'hFE, 16'd1);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("wrap_fe", 1'b1, 32'h0201_5A5B, 8'hFE, 8'h02, 16'd1);

        // Jump while holding without ready: no count
        step(1'b0, 1'b0, 1'b1, 8'h04, 1'b0);
        chk_all("jump_noacc", 1'b0, 32'h0201_5A5B, 8'hFE, 8'h04, 16'd1);

        // Three-cycle halt after the first byte delays valid by exactly three cycles
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk_all($sformatf("halt%0d", c), 1'b0, 32'h0000_0001, 8'h00, 8'h01, 16'd0);
        end
        for (int c = 0; c < 2; c++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk({"halt_early", ".valid"}, {31'd0, instr_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("halt_done", 1'b1, 32'h0403_0201, 8'h00, 8'h04, 16'd0);

        // Halt during hold does not block the accept
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk_all("halt_hold_acc", 1'b0, 32'h0403_0201, 8'h00, 8'h04, 16'd1);

        // Reset while valid (with jump and halt also high) clears everything
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("pre_rst", 1'b1, 32'h0807_0605, 8'h04, 8'h08, 16'd1);
        step(1'b1, 1'b1, 1'b1, 8'h40, 1'b0);
        chk_all("rst_hold", 1'b0, 32'h0000_0000, 8'h00, 8'h00, 16'd0);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_all("refetch", 1'b1, 32'h0403_0201, 8'h00, 8'h04, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_fetch8.md
PROG_FETCH8 -- requirements
Module: prog_fetch8

Interface
REQ-001 Parameter INSTR_BYTES, default 4: bytes per instruction, legal range 1..4.
REQ-002 Parameter RESET_PC, default 8'h00: fetch address after reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 mem_addr  output  8  byte address to program memory (combinational-read, byte-wide).
REQ-006 mem_data  input  8  byte returned for mem_addr in the same cycle.
REQ-007 halt  input  1  freezes fetching while high.
REQ-008 jump_en  input  1  redirect request.
REQ-009 jump_addr  input  8  redirect target address.
REQ-010 instr  output  32  assembled instruction; unused upper bytes zero.
REQ-011 instr_pc  output  8  address of the first byte of instr.
REQ-012 instr_valid  output  1  instr/instr_pc hold a complete instruction.
REQ-013 instr_ready  input  1  downstream accepts instr this cycle.
REQ-014 fetch_count  output  16  count of accepted instructions, saturating.

Function
REQ-015 Internal state: fetch pointer fptr[7:0], byte index idx[1:0], FSM {FETCH, HOLD}.
REQ-016 mem_addr SHALL equal fptr combinationally at all times.
REQ-017 FETCH, halt low, no jump: capture mem_data into instr byte idx (byte 0 = bits 7:0, little-endian), fptr+1, idx+1.
REQ-018 FETCH, idx 0 capture: instr_pc <= fptr; bytes above INSTR_BYTES-1 cleared to zero.
REQ-019 Capture of byte INSTR_BYTES-1: idx <= 0, state -> HOLD, instr_valid = 1 from the next cycle.
REQ-020 Latency: first instr_valid exactly INSTR_BYTES cycles after rst deasserts (no halt, no jump).
REQ-021 HOLD: instr, instr_pc, instr_valid stable; fptr held at the next instruction address; no memory capture.
REQ-022 HOLD with instr_ready high: accept; fetch_count+1 (holds at 16'hFFFF); state -> FETCH; instr_valid 0 next cycle.
REQ-023 instr_valid SHALL be high only in HOLD; instr_ready ignored when instr_valid low.
REQ-024 fptr arithmetic modulo 256: 8'hFF increments to 8'h00; an instruction may span the wrap.
REQ-025 halt high in FETCH: no capture, fptr/idx unchanged; resume on same byte when halt falls.
REQ-026 halt high in HOLD: no effect; accept still permitted.
REQ-027 jump_en high (any state): fptr <= jump_addr, idx <= 0, state -> FETCH, instr_valid 0 next cycle; partial bytes discarded.
REQ-028 jump_en with instr_valid and instr_ready same cycle: instruction counts as accepted (fetch_count+1), then jump applies.
REQ-029 jump_en SHALL take priority over halt and over byte capture in the same cycle.
REQ-030 instr_ready SHALL not combinationally affect any output.

Reset
REQ-031 rst high at a clock edge: fptr = RESET_PC, idx = 0, state FETCH, instr = 0, instr_pc = 0, instr_valid = 0, fetch_count = 0.
REQ-032 rst SHALL override halt and jump_en; rst mid-fetch or mid-HOLD discards all partial/held data.
REQ-033 First capture occurs on the first rising edge with rst low.

Verification
REQ-034 Memory bytes 00..07 = 01 02 03 04 05 06 07 08, instr_ready high -> instr 32'h04030201 pc 00, then 32'h08070605 pc 04; valid 1 cycle each, 5 cycles apart.
REQ-035 instr_ready low 10 cycles after valid -> instr/instr_pc stable, mem_addr 04, fetch_count unchanged; accepted on ready, count+1.
REQ-036 jump_en with jump_addr 8'h80 after 2 bytes captured -> next valid instr from bytes 80..83, instr_pc 80; discarded bytes absent.
REQ-037 Jump to 8'hFE, INSTR_BYTES 4 -> instr from addresses FE,FF,00,01; instr_pc FE; mem_addr then 02.
REQ-038 halt pulsed 3 cycles mid-fetch -> valid delayed exactly 3 cycles, instr unchanged vs no-halt run.
REQ-039 rst asserted while instr_valid high -> next cycle valid 0, mem_addr RESET_PC, fetch_count 0; refetch from RESET_PC.
